iomem_gpio_bank: RTL and testbench
==================================

// Module: iomem_gpio_bank
// PURPOSE
//  Parametrised GPIO peripheral slave on the picosoc iomem bus; successor to the single fixed 32-bit GPIO latch.
//  Adds per-pin output enable, synchronised input readback, byte-lane writes on all registers, and edge-triggered
//  interrupts (optional). Sits beside picosoc in the top level; drives io_out/io_oeb slices and an irq_N input.
// PARAMETERS
//  NUM_GPIO   32      number of pins, 1..32; register bits >= NUM_GPIO read 0, writes ignored
//  BASE_SEL   8'h03   value matched against iomem_addr[31:24] to select this block
//  SYNC_DEPTH 2       input synchroniser flops, 2..3
// PORTS
//  clk          in   1         system clock
//  resetn       in   1         asynchronous active-low reset
//  iomem_valid  in   1         request valid
//  iomem_ready  out  1         one-cycle completion pulse
//  iomem_wstrb  in   4         byte write strobes; 4'b0000 = read
//  iomem_addr   in   32        byte address; [31:24] select, [7:2] register offset
//  iomem_wdata  in   32        write data
//  iomem_rdata  out  32        registered read data, valid while iomem_ready=1
//  gpio_in      in   NUM_GPIO  asynchronous pin inputs
//  gpio_out     out  NUM_GPIO  pin output values
//  gpio_oe      out  NUM_GPIO  1 = pin driven (top level forms io_oeb = ~gpio_oe)
//  irq          out  1         level interrupt to picosoc
// BEHAVIOUR
//  Reset (async, resetn=0): iomem_ready=0, iomem_rdata=0, gpio_out=0, gpio_oe=0 (all inputs), irq=0,
//   all registers and synchroniser flops cleared. Reset mid-access aborts it; no ready is issued for it.
//  Accept: iomem_valid && !iomem_ready && addr[31:24]==BASE_SEL. Next cycle: iomem_ready=1 for exactly one cycle,
//   iomem_rdata = pre-write register value, write takes effect at the same edge. Latency 1; back-to-back
//   accesses therefore complete every 2 cycles. Non-selected addresses: no response, no state change.
//  Register map (offset = addr[7:0]; unlisted offsets: read 0, writes ignored, ready still returned):
//   0x00 OUT     RW  drives gpio_out
//   0x04 OE      RW  drives gpio_oe
//   0x08 IN      RO  synchronised gpio_in; writes ignored
//   0x0C IRQ_EN  RW  per-pin interrupt enable
//   0x10 IRQ_POL RW  per-pin edge select: 1 = rising, 0 = falling
//   0x14 IRQ_STS W1C per-pin pending flag; writing 1 clears, writing 0 no effect
//  Byte lanes: wstrb[k] gates bits [8k+7:8k] on every RW/W1C register.
//  Inputs: gpio_in -> SYNC_DEPTH flops -> sync; prev = sync delayed 1 cycle. IN reflects sync.
//   Pin change to IN visible: SYNC_DEPTH cycles. Pulses shorter than 1 clk may be lost.
//  Edge: edge[i] = POL[i] ? (sync & ~prev) : (~sync & prev). STS[i] sets on edge[i] regardless of EN[i].
//   Simultaneous W1C and new edge on same bit: set wins (STS stays 1).
//  irq = |(STS & EN), registered (1 cycle after STS/EN change).
//  Pin reads back its own driven value only via external loopback; IN never muxes gpio_out.
// CONFIGURATION
//  GPIO_IRQ_EN defined: IRQ_EN/IRQ_POL/IRQ_STS and edge logic present as above.
//  GPIO_IRQ_EN undefined: offsets 0x0C-0x14 read 0 and ignore writes, no edge/prev flops, irq tied 0;
//   OUT/OE/IN behaviour and timing identical.
// STRUCTURE
//  Package iomem_gpio_pkg: register offset localparams (GPIO_OFF_OUT..GPIO_OFF_STS), DEFAULT_BASE_SEL, reset values.
//  Sub-module gpio_in_sync (NUM_GPIO, SYNC_DEPTH): synchroniser chain + prev register, outputs sync/rise/fall.
//  Top of block: bus decode, register file, rdata mux, irq reduction.
// TESTING
//  1 Reset: hold resetn=0 mid-request -> ready 0, gpio_oe=0, gpio_out=0, irq=0; release, read 0x00 -> 0.
//  2 Write 0x00=0xA5A5_5A5A with wstrb=4'b0101 after reset -> OUT reads 0x00A5_005A; ready high exactly 1 cycle.
//  3 Write OE=0x0000_00FF, OUT=0x0000_0003 -> gpio_oe[7:0]=1, gpio_out[1:0]=1; addr 0x0400_0000 -> no ready.
//  4 Drive gpio_in[4] 0->1 -> IN bit 4 set after 2 clks; with POL[4]=1, EN[4]=1 -> STS=0x10, irq=1 next cycle.
//  5 W1C STS=0x10 on the same cycle a new rising edge hits bit 4 -> STS stays 0x10; next W1C alone -> STS=0, irq=0.
//  6 NUM_GPIO=8 build: write 0x00=0xFFFF_FFFF -> reads 0x0000_00FF; GPIO_IRQ_EN undefined -> 0x14 reads 0, irq 0.

Source files
------------

// File: rtl/iomem_gpio_bank_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : iomem_gpio_pkg
//  Purpose  : Shared definitions for the iomem GPIO bank: register offsets,
//             default block select, reset values and bus FSM encoding.
//  Revision : 1.0  initial release
// ============================================================================
package iomem_gpio_pkg;

    // Value matched against iomem_addr[31:24]
    localparam logic [7:0] DEFAULT_BASE_SEL = 8'h03;

    // Register byte offsets
    localparam logic [7:0] GPIO_OFF_OUT = 8'h00;
    localparam logic [7:0] GPIO_OFF_OE  = 8'h04;
    localparam logic [7:0] GPIO_OFF_IN  = 8'h08;
    localparam logic [7:0] GPIO_OFF_EN  = 8'h0C;
    localparam logic [7:0] GPIO_OFF_POL = 8'h10;
    localparam logic [7:0] GPIO_OFF_STS = 8'h14;

    // Register reset values
    localparam logic [31:0] GPIO_RST_OUT = 32'h0000_0000;
    localparam logic [31:0] GPIO_RST_OE  = 32'h0000_0000;
    localparam logic [31:0] GPIO_RST_EN  = 32'h0000_0000;
    localparam logic [31:0] GPIO_RST_POL = 32'h0000_0000;
    localparam logic [31:0] GPIO_RST_STS = 32'h0000_0000;

    // Bus response state: IDLE accepts, RESP presents ready for one cycle
    typedef enum logic [0:0] {
        BUS_IDLE = 1'b0,
        BUS_RESP = 1'b1
    } bus_state_e;

    // Word index of a register, as decoded from iomem_addr[7:2]
    function automatic logic [5:0] reg_word(input logic [7:0] off);
        return off[7:2];
    endfunction

endpackage
`default_nettype wire

// File: rtl/iomem_gpio_bank_if.sv
`default_nettype none
// ============================================================================
//  Module   : iomem_gpio_bank_if
//  Purpose  : picosoc iomem bus bundle (valid/ready request-response).
//  Revision : 1.0  initial release
// ============================================================================
interface iomem_gpio_bank_if;
    logic        iomem_valid;
    logic        iomem_ready;
    logic [3:0]  iomem_wstrb;
    logic [31:0] iomem_addr;
    logic [31:0] iomem_wdata;
    logic [31:0] iomem_rdata;

    modport master (
        output iomem_valid, iomem_wstrb, iomem_addr, iomem_wdata,
        input  iomem_ready, iomem_rdata
    );

    modport slave (
        input  iomem_valid, iomem_wstrb, iomem_addr, iomem_wdata,
        output iomem_ready, iomem_rdata
    );
endinterface
`default_nettype wire

// File: rtl/iomem_gpio_bank_gpio_in_sync.sv
`default_nettype none
// ============================================================================
//  Module   : gpio_in_sync
//  Purpose  : Multi-flop synchroniser for asynchronous pin inputs plus a
//             one-cycle-delayed copy for rising/falling edge detection.
//             Edge logic exists only when GPIO_IRQ_EN is defined; otherwise
//             rise/fall are constant zero and no delay flops are built.
//  Revision : 1.0  initial release
// ============================================================================
module gpio_in_sync #(
    parameter int NUM_GPIO   = 32,
    parameter int SYNC_DEPTH = 2
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic [NUM_GPIO-1:0] din,
    output logic [NUM_GPIO-1:0] sync,
    output logic [NUM_GPIO-1:0] rise,
    output logic [NUM_GPIO-1:0] fall
);

    logic [NUM_GPIO-1:0] r_chain [SYNC_DEPTH];

    // Shift the raw pins through SYNC_DEPTH flops
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < SYNC_DEPTH; i++) begin
                r_chain[i] <= '0;
            end
        end else begin
            r_chain[0] <= din;
            for (int i = 1; i < SYNC_DEPTH; i++) begin
                r_chain[i] <= r_chain[i-1];
            end
        end
    end

    assign sync = r_chain[SYNC_DEPTH-1];

`ifdef GPIO_IRQ_EN
    logic [NUM_GPIO-1:0] r_prev;

    // Previous synchronised value, for edge detection
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_prev <= '0;
        end else begin
            r_prev <= sync;
        end
    end

    assign rise = sync & ~r_prev;
    assign fall = ~sync & r_prev;
`else
    assign rise = '0;
    assign fall = '0;
`endif

endmodule
`default_nettype wire

// File: rtl/iomem_gpio_bank.sv
`default_nettype none
// ============================================================================
//  Module   : iomem_gpio_bank
//  Purpose  : Parametrised GPIO slave on the picosoc iomem bus: OUT/OE/IN
//             registers with byte-lane writes, synchronised input readback
//             and, when GPIO_IRQ_EN is defined, per-pin edge interrupts
//             (IRQ_EN / IRQ_POL / IRQ_STS) reduced to a level irq.
//  Revision : 1.0  initial release
// ============================================================================
module iomem_gpio_bank
    import iomem_gpio_pkg::*;
#(
    parameter int         NUM_GPIO   = 32,
    parameter logic [7:0] BASE_SEL   = DEFAULT_BASE_SEL,
    parameter int         SYNC_DEPTH = 2
) (
    input  logic                clk,
    input  logic                resetn,
    iomem_gpio_bank_if.slave    iomem,
    input  logic [NUM_GPIO-1:0] gpio_in,
    output logic [NUM_GPIO-1:0] gpio_out,
    output logic [NUM_GPIO-1:0] gpio_oe,
    output logic                irq
);

    localparam logic [5:0] c_W_OUT = reg_word(GPIO_OFF_OUT);
    localparam logic [5:0] c_W_OE  = reg_word(GPIO_OFF_OE);
    localparam logic [5:0] c_W_IN  = reg_word(GPIO_OFF_IN);

    bus_state_e          r_state;
    bus_state_e          w_state_next;
    logic                w_sel;
    logic                w_accept;
    logic                w_wr;
    logic [5:0]          w_word;
    logic [31:0]         r_rdata;
    logic [31:0]         w_rdata_next;
    logic [NUM_GPIO-1:0] w_msk;
    logic [NUM_GPIO-1:0] w_wd;
    logic [NUM_GPIO-1:0] r_out;
    logic [NUM_GPIO-1:0] r_oe;
    logic [NUM_GPIO-1:0] w_sync;
    logic [NUM_GPIO-1:0] w_rise;
    logic [NUM_GPIO-1:0] w_fall;
    logic                w_addr_unused;

    // Address bits outside the select and word fields carry no meaning here
    assign w_addr_unused = ^{iomem.iomem_addr[23:8], iomem.iomem_addr[1:0]};

    assign w_sel  = iomem.iomem_valid && (iomem.iomem_addr[31:24] == BASE_SEL);
    assign w_word = iomem.iomem_addr[7:2];
    assign w_wr   = w_accept && (iomem.iomem_wstrb != 4'b0000);

    // Expand byte strobes to a per-pin write mask and gate write data with it
    always_comb begin
        w_msk = '0;
        for (int i = 0; i < NUM_GPIO; i++) begin
            w_msk[i] = iomem.iomem_wstrb[i/8];
        end
        w_wd = iomem.iomem_wdata[NUM_GPIO-1:0] & w_msk;
    end

    generate
        if (NUM_GPIO < 32) begin : g_pad
            logic w_pad_unused;
            assign w_pad_unused = ^iomem.iomem_wdata[31:NUM_GPIO];
        end
    endgenerate

    gpio_in_sync #(
        .NUM_GPIO   (NUM_GPIO),
        .SYNC_DEPTH (SYNC_DEPTH)
    ) u_in_sync (
        .clk    (clk),
        .resetn (resetn),
        .din    (gpio_in),
        .sync   (w_sync),
        .rise   (w_rise),
        .fall   (w_fall)
    );

    // Bus FSM state register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= BUS_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Bus FSM: accept only in IDLE, so ready is a single-cycle pulse
    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        case (r_state)
            BUS_IDLE: begin
                if (w_sel) begin
                    w_accept     = 1'b1;
                    w_state_next = BUS_RESP;
                end
            end
            BUS_RESP: begin
                w_state_next = BUS_IDLE;
            end
            default: begin
                w_state_next = BUS_IDLE;
            end
        endcase
    end

    assign iomem.iomem_ready = (r_state == BUS_RESP);
    assign iomem.iomem_rdata = r_rdata;

    // OUT and OE registers with byte-lane writes
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_out <= GPIO_RST_OUT[NUM_GPIO-1:0];
            r_oe  <= GPIO_RST_OE[NUM_GPIO-1:0];
        end else if (w_wr) begin
            if (w_word == c_W_OUT) begin
                r_out <= (r_out & ~w_msk) | w_wd;
            end
            if (w_word == c_W_OE) begin
                r_oe <= (r_oe & ~w_msk) | w_wd;
            end
        end
    end

    assign gpio_out = r_out;
    assign gpio_oe  = r_oe;

`ifdef GPIO_IRQ_EN
    localparam logic [5:0] c_W_EN  = reg_word(GPIO_OFF_EN);
    localparam logic [5:0] c_W_POL = reg_word(GPIO_OFF_POL);
    localparam logic [5:0] c_W_STS = reg_word(GPIO_OFF_STS);

    logic [NUM_GPIO-1:0] r_en;
    logic [NUM_GPIO-1:0] r_pol;
    logic [NUM_GPIO-1:0] r_sts;
    logic [NUM_GPIO-1:0] w_edge;
    logic [NUM_GPIO-1:0] w_clr;
    logic                r_irq;

    assign w_edge = (r_pol & w_rise) | (~r_pol & w_fall);
    assign w_clr  = (w_wr && (w_word == c_W_STS)) ? w_wd : '0;

    // Interrupt configuration and pending flags; a new edge beats a W1C
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_en  <= GPIO_RST_EN[NUM_GPIO-1:0];
            r_pol <= GPIO_RST_POL[NUM_GPIO-1:0];
            r_sts <= GPIO_RST_STS[NUM_GPIO-1:0];
        end else begin
            if (w_wr && (w_word == c_W_EN)) begin
                r_en <= (r_en & ~w_msk) | w_wd;
            end
            if (w_wr && (w_word == c_W_POL)) begin
                r_pol <= (r_pol & ~w_msk) | w_wd;
            end
            r_sts <= (r_sts & ~w_clr) | w_edge;
        end
    end

    // Registered interrupt level
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_irq <= 1'b0;
        end else begin
            r_irq <= |(r_sts & r_en);
        end
    end

    assign irq = r_irq;
`else
    logic w_edge_unused;
    assign w_edge_unused = ^{w_rise, w_fall};
    assign irq = 1'b0;
`endif

    // Read mux: value of the addressed register before any write this cycle
    always_comb begin
        w_rdata_next = 32'h0000_0000;
        case (w_word)
            c_W_OUT: w_rdata_next = 32'(r_out);
            c_W_OE:  w_rdata_next = 32'(r_oe);
            c_W_IN:  w_rdata_next = 32'(w_sync);
`ifdef GPIO_IRQ_EN
            c_W_EN:  w_rdata_next = 32'(r_en);
            c_W_POL: w_rdata_next = 32'(r_pol);
            c_W_STS: w_rdata_next = 32'(r_sts);
`endif
            default: w_rdata_next = 32'h0000_0000;
        endcase
    end

    // Capture read data at the accepting edge
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_rdata <= 32'h0000_0000;
        end else if (w_accept) begin
            r_rdata <= w_rdata_next;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_iomem_gpio_bank.sv
`default_nettype none
// ============================================================================
//  Module   : tb_iomem_gpio_bank
//  Purpose  : Self-checking bench for iomem_gpio_bank (32-pin and 8-pin
//             instances): directed vector table, multi-cycle corner
//             sequences and randomized traffic against a register model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_iomem_gpio_bank;
    import iomem_gpio_pkg::*;

`ifdef GPIO_IRQ_EN
    localparam bit IRQ_ON = 1'b1;
`else
    localparam bit IRQ_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic [31:0] gpio_in = '0;
    logic [31:0] gpio_out;
    logic [31:0] gpio_oe;
    logic        irq;
    logic [7:0]  gpio_in8 = '0;
    logic [7:0]  gpio_out8;
    logic [7:0]  gpio_oe8;
    logic        irq8;

    iomem_gpio_bank_if bus ();
    iomem_gpio_bank_if bus8 ();

    always #5 clk = ~clk;

    iomem_gpio_bank #(.NUM_GPIO(32), .BASE_SEL(8'h03), .SYNC_DEPTH(2)) u_dut (
        .clk(clk), .resetn(resetn), .iomem(bus),
        .gpio_in(gpio_in), .gpio_out(gpio_out), .gpio_oe(gpio_oe), .irq(irq)
    );

    iomem_gpio_bank #(.NUM_GPIO(8), .BASE_SEL(8'h03), .SYNC_DEPTH(3)) u_dut8 (
        .clk(clk), .resetn(resetn), .iomem(bus8),
        .gpio_in(gpio_in8), .gpio_out(gpio_out8), .gpio_oe(gpio_oe8), .irq(irq8)
    );

    int checks = 0;
    int failures = 0;

    // Register model of the 32-pin instance
    logic [31:0] m_out, m_oe, m_en, m_pol, m_sts, m_in;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  strb;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;

    vec_t tbl[19];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] ra(input logic [7:0] off);
        return {8'h03, 16'h0000, off};
    endfunction

    function automatic logic [31:0] lanes(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [3:0] strb);
        logic [31:0] r;
        r = old;
        for (int k = 0; k < 4; k++) if (strb[k]) r[8*k +: 8] = wd[8*k +: 8];
        return r;
    endfunction

    function automatic logic [31:0] m_read(input logic [7:0] off);
        case (off)
            8'h00:   return m_out;
            8'h04:   return m_oe;
            8'h08:   return m_in;
            8'h0C:   return m_en;
            8'h10:   return m_pol;
            8'h14:   return m_sts;
            default: return 32'h0;
        endcase
    endfunction

    task automatic m_write(input logic [7:0] off, input logic [3:0] strb, input logic [31:0] wd);
        if (strb != 4'b0000) begin
            case (off)
                8'h00: m_out = lanes(m_out, wd, strb);
                8'h04: m_oe  = lanes(m_oe, wd, strb);
                8'h0C: if (IRQ_ON) m_en  = lanes(m_en, wd, strb);
                8'h10: if (IRQ_ON) m_pol = lanes(m_pol, wd, strb);
                8'h14: if (IRQ_ON) m_sts = m_sts & ~lanes(32'h0, wd, strb);
                default: ;
            endcase
        end
    endtask

    task automatic m_pins(input logic [31:0] nv);
        if (IRQ_ON) m_sts = m_sts | (m_pol & nv & ~m_in) | (~m_pol & ~nv & m_in);
        m_in = nv;
    endtask

    task automatic m_reset();
        m_out = 0; m_oe = 0; m_en = 0; m_pol = 0; m_sts = 0; m_in = 0;
    endtask

    // One bus access; returns read data, whether ready came, and whether
    // ready was still high in the following cycle
    task automatic xfer(input bit d8, input logic [31:0] a, input logic [3:0] s,
                        input logic [31:0] wd, output logic [31:0] rd,
                        output bit got, output bit extra);
        int n;
        n = 0; got = 1'b0; extra = 1'b0; rd = '0;
        if (d8) begin
            bus8.iomem_valid = 1'b1; bus8.iomem_addr = a; bus8.iomem_wstrb = s; bus8.iomem_wdata = wd;
        end else begin
            bus.iomem_valid = 1'b1; bus.iomem_addr = a; bus.iomem_wstrb = s; bus.iomem_wdata = wd;
        end
        while (!got && n < 6) begin
            @(posedge clk); #1;
            n++;
            if (d8 ? bus8.iomem_ready : bus.iomem_ready) begin
                got = 1'b1;
                rd = d8 ? bus8.iomem_rdata : bus.iomem_rdata;
            end
        end
        bus.iomem_valid = 1'b0;
        bus8.iomem_valid = 1'b0;
        @(posedge clk); #1;
        extra = d8 ? bus8.iomem_ready : bus.iomem_ready;
    endtask

    // Access with ready/data checks folded in
    task automatic acc(input string nm, input bit d8, input logic [31:0] a, input logic [3:0] s,
                       input logic [31:0] wd, input logic [31:0] exp);
        logic [31:0] rd;
        bit got, extra;
        xfer(d8, a, s, wd, rd, got, extra);
        chk({nm, "_ready"}, 32'(got), 32'd1);
        chk({nm, "_rdata"}, rd, exp);
        chk({nm, "_ready_1cyc"}, 32'(extra), 32'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        bit got, extra;

        bus.iomem_valid = 0;  bus.iomem_addr = 0;  bus.iomem_wstrb = 0;  bus.iomem_wdata = 0;
        bus8.iomem_valid = 0; bus8.iomem_addr = 0; bus8.iomem_wstrb = 0; bus8.iomem_wdata = 0;
        m_reset();

        // Reset state, with a request pending during reset
        resetn = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        bus.iomem_valid = 1'b1; bus.iomem_addr = ra(8'h00); bus.iomem_wstrb = 4'hF; bus.iomem_wdata = '1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", 32'(bus.iomem_ready), 0);
        chk("rst_rdata", bus.iomem_rdata, 0);
        chk("rst_out", gpio_out, 0);
        chk("rst_oe", gpio_oe, 0);
        chk("rst_irq", 32'(irq), 0);
        bus.iomem_valid = 1'b0;
        resetn = 1'b1;
        @(posedge clk); #1;
        acc("rst_read_out", 0, ra(8'h00), 4'h0, 0, 0);

        // Directed register vectors
        tbl[0]  = '{ra(8'h00), 4'b0101, 32'hA5A5_5A5A, 32'h0};
        tbl[1]  = '{ra(8'h00), 4'b0000, 32'h0,         32'h00A5_005A};
        tbl[2]  = '{ra(8'h00), 4'b1010, 32'hFFFF_FFFF, 32'h00A5_005A};
        tbl[3]  = '{ra(8'h00), 4'b0000, 32'h0,         32'hFFA5_FF5A};
        tbl[4]  = '{ra(8'h04), 4'b1111, 32'h0000_00FF, 32'h0};
        tbl[5]  = '{ra(8'h00), 4'b1111, 32'h0000_0003, 32'hFFA5_FF5A};
        tbl[6]  = '{ra(8'h04), 4'b0000, 32'h0,         32'h0000_00FF};
        tbl[7]  = '{ra(8'h00), 4'b0000, 32'h0,         32'h0000_0003};
        tbl[8]  = '{ra(8'h08), 4'b1111, 32'hFFFF_FFFF, 32'h0};
        tbl[9]  = '{ra(8'h08), 4'b0000, 32'h0,         32'h0};
        tbl[10] = '{ra(8'h18), 4'b1111, 32'hFFFF_FFFF, 32'h0};
        tbl[11] = '{ra(8'h18), 4'b0000, 32'h0,         32'h0};
        tbl[12] = '{ra(8'h3C), 4'b0000, 32'h0,         32'h0};
        tbl[13] = '{ra(8'h0C), 4'b0011, 32'h1234_5678, 32'h0};
        tbl[14] = '{ra(8'h0C), 4'b0000, 32'h0,         IRQ_ON ? 32'h0000_5678 : 32'h0};
        tbl[15] = '{ra(8'h10), 4'b1000, 32'hFFFF_FFFF, 32'h0};
        tbl[16] = '{ra(8'h10), 4'b0000, 32'h0,         IRQ_ON ? 32'hFF00_0000 : 32'h0};
        tbl[17] = '{ra(8'h14), 4'b0000, 32'h0,         32'h0};
        tbl[18] = '{ra(8'h04), 4'b0000, 32'h0,         32'h0000_00FF};
        for (int i = 0; i < 19; i++) begin
            acc($sformatf("vec%0d", i), 0, tbl[i].addr, tbl[i].strb, tbl[i].wdata, tbl[i].exp);
        end
        chk("vec_gpio_oe", gpio_oe, 32'h0000_00FF);
        chk("vec_gpio_out", gpio_out, 32'h0000_0003);
        chk("vec_irq", 32'(irq), 0);

        // Non-selected address: no response, no state change
        xfer(0, 32'h0400_0000, 4'hF, 32'hFFFF_FFFF, rd, got, extra);
        chk("nosel_ready", 32'(got), 0);
        acc("nosel_out_kept", 0, ra(8'h00), 4'h0, 0, 32'h3);

        // Back-to-back: valid held high, ready on alternate cycles
        bus.iomem_valid = 1'b1; bus.iomem_addr = ra(8'h00); bus.iomem_wstrb = 4'h0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            chk($sformatf("b2b_ready%0d", i), 32'(bus.iomem_ready), (i % 2 == 0) ? 32'd1 : 32'd0);
        end
        bus.iomem_valid = 1'b0;
        @(posedge clk); #1;

        // Rising edge on pin 4: IN latency, STS and irq timing
        acc("irq_pol", 0, ra(8'h10), 4'hF, 32'h10, IRQ_ON ? 32'hFF00_0000 : 32'h0);
        acc("irq_en", 0, ra(8'h0C), 4'hF, 32'h10, IRQ_ON ? 32'h0000_5678 : 32'h0);
        gpio_in[4] = 1'b1;
        @(posedge clk); #1;
        acc("in_early", 0, ra(8'h08), 4'h0, 0, 32'h0);
        chk("irq_not_yet", 32'(irq), 0);
        acc("in_late", 0, ra(8'h08), 4'h0, 0, 32'h10);
        chk("irq_set", 32'(irq), 32'(IRQ_ON));
        acc("sts_set", 0, ra(8'h14), 4'h0, 0, IRQ_ON ? 32'h10 : 32'h0);

        // W1C coinciding with a new rising edge: set wins
        gpio_in[4] = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        gpio_in[4] = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        acc("w1c_race", 0, ra(8'h14), 4'b0001, 32'h10, IRQ_ON ? 32'h10 : 32'h0);
        acc("sts_kept", 0, ra(8'h14), 4'h0, 0, IRQ_ON ? 32'h10 : 32'h0);
        chk("irq_kept", 32'(irq), 32'(IRQ_ON));
        acc("w1c_alone", 0, ra(8'h14), 4'b0001, 32'h10, IRQ_ON ? 32'h10 : 32'h0);
        acc("sts_clear", 0, ra(8'h14), 4'h0, 0, 32'h0);
        chk("irq_clear", 32'(irq), 0);

        // 8-pin instance, 3-stage synchroniser
        acc("g8_wr_out", 1, ra(8'h00), 4'hF, 32'hFFFF_FFFF, 32'h0);
        acc("g8_rd_out", 1, ra(8'h00), 4'h0, 0, 32'h0000_00FF);
        chk("g8_gpio_out", 32'(gpio_out8), 32'hFF);
        acc("g8_wr_oe", 1, ra(8'h04), 4'hF, 32'h1234_5678, 32'h0);
        acc("g8_rd_oe", 1, ra(8'h04), 4'h0, 0, 32'h0000_0078);
        chk("g8_gpio_oe", 32'(gpio_oe8), 32'h78);
        gpio_in8 = 8'h5A;
        repeat (2) @(posedge clk);
        #1;
        acc("g8_in_early", 1, ra(8'h08), 4'h0, 0, 32'h0);
        acc("g8_in_late", 1, ra(8'h08), 4'h0, 0, 32'h5A);
        acc("g8_sts", 1, ra(8'h14), 4'h0, 0, 32'h0);
        chk("g8_irq", 32'(irq8), 0);

        // Reset asserted in the middle of an access aborts it
        gpio_in = '0;
        repeat (5) @(posedge clk);
        #1;
        bus.iomem_valid = 1'b1; bus.iomem_addr = ra(8'h04); bus.iomem_wstrb = 4'hF; bus.iomem_wdata = '1;
        #3 resetn = 1'b0;
        @(posedge clk); #1;
        chk("midrst_ready", 32'(bus.iomem_ready), 0);
        chk("midrst_out", gpio_out, 0);
        chk("midrst_oe", gpio_oe, 0);
        chk("midrst_irq", 32'(irq), 0);
        bus.iomem_valid = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        @(posedge clk); #1;
        m_reset();
        acc("midrst_rd_oe", 0, ra(8'h04), 4'h0, 0, 32'h0);

        // Randomized traffic against the register model
        for (int it = 0; it < 300; it++) begin
            int r;
            r = $urandom_range(0, 9);
            if (r < 2) begin
                logic [31:0] nv;
                nv = $urandom;
                gpio_in = nv;
                repeat (5) @(posedge clk);
                #1;
                m_pins(nv);
            end else if (r == 2) begin
                logic [7:0] sel;
                sel = 8'($urandom_range(0, 255));
                if (sel == 8'h03) sel = 8'h04;
                xfer(0, {sel, 16'h0, 8'h00}, 4'hF, $urandom, rd, got, extra);
                chk("rnd_nosel", 32'(got), 0);
            end else begin
                int w;
                logic [7:0]  off;
                logic [3:0]  s;
                logic [31:0] wd;
                w   = $urandom_range(0, 8);
                off = (w == 8) ? 8'h40 : 8'(w * 4);
                s   = ($urandom_range(0, 3) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
                wd  = $urandom;
                acc($sformatf("rnd_off%02h", off), 0, ra(off), s, wd, m_read(off));
                m_write(off, s, wd);
            end
            chk("rnd_gpio_out", gpio_out, m_out);
            chk("rnd_gpio_oe", gpio_oe, m_oe);
            chk("rnd_irq", 32'(irq), 32'(|(m_sts & m_en)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
